dmem_mmio_bridge: RTL and testbench
===================================

Name: dmem_mmio_bridge

Overview:
- Sits between the processor's data-memory port and the dmem syncram; runs on the fast `clock` that also drives dmem.
- Decodes the 12-bit processor data address:
  - Addresses below MMIO_BASE pass through to dmem.
  - The top page is memory-mapped I/O: a debug output FIFO with a ready/valid drain port, a FIFO status register, and a free-running 32-bit cycle counter.
- Returns read data to the processor with the same one-cycle latency as the syncram.

Parameters:
- FIFO_DEPTH, 4, entries in debug FIFO; power of two, 2..16.
- MMIO_BASE, 12'hF00, first MMIO word address; addresses >= MMIO_BASE never reach dmem.

Ports:
- clock  in  1  fast clock, same as dmem clock.
- reset  in  1  synchronous, active-high.
- proc_step  in  1  one-cycle pulse in the fast cycle where processor outputs are new; gates all side effects.
- address_dmem  in  12  processor data word address.
- data  in  32  processor store data.
- wren  in  1  processor write enable.
- q_dmem  out  32  read data to processor.
- mem_address  out  12  to dmem.
- mem_data  out  32  to dmem.
- mem_wren  out  1  to dmem.
- mem_q  in  32  from dmem.
- dbg_valid  out  1  FIFO head valid.
- dbg_data  out  32  FIFO head word.
- dbg_ready  in  1  consumer accepts head.

Behaviour:
- Decode, combinational:
  - is_mem = address_dmem < MMIO_BASE.
  - mem_address = address_dmem.
  - mem_data = data.
  - mem_wren = wren & is_mem. Held for all cycles the processor holds it; dmem writes are idempotent.
- MMIO map, by offset from MMIO_BASE:
  - +0: write pushes `data` into the FIFO. Reads return 0.
  - +1: read returns {29'b0, overflow, full, empty}. Any write clears overflow.
  - +2: read returns cycle_count.
  - +3: write clears cycle_count. Reads return 0.
  - +4 and above: reads return 0, writes are ignored.
- Side effects (push, overflow clear, counter clear) commit only in a cycle where proc_step & wren & matching address. Exactly one commit per processor store.
- Read path:
  - Register sel_mem <= is_mem and mmio_rd <= decoded MMIO value every cycle.
  - q_dmem = sel_mem ? mem_q : mmio_rd.
  - Latency is one clock from address to q_dmem for both regions.
  - The status value is sampled pre-update, i.e. the state before any same-cycle push or pop.
- Cycle counter:
  - 32-bit; increments every clock; wraps 0xFFFFFFFF -> 0.
  - A clear commit sets it to 0 next cycle; clear wins over increment.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count (0..FIFO_DEPTH).
  - dbg_valid = (count != 0). dbg_data = mem[rd_ptr], stable while dbg_valid & !dbg_ready.
  - Pop when dbg_valid & dbg_ready.
  - Push when a push commit occurs and (count < FIFO_DEPTH or pop in the same cycle).
  - Push while full with no pop: word dropped, overflow <= 1 (sticky until a status write or reset).
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Empty plus push: no bypass. dbg_valid rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (synchronous, active-high):
  - Clears count, pointers, overflow, cycle_count, sel_mem, and mmio_rd.
  - Outputs after reset: dbg_valid=0, q_dmem=0 (sel_mem=0 selects mmio_rd=0), dbg_data=don't-care.
  - Reset mid-transfer discards FIFO contents; no pop is reported.
  - Reset has priority over all commits in the same cycle.

Test Plan:
- Passthrough: store 0xDEADBEEF at 0x010 with proc_step -> mem_wren=1, mem_address=0x010; load 0x010 -> q_dmem=0xDEADBEEF one cycle after address.
- MMIO isolation: store to 0xF00 -> mem_wren=0; dbg_valid=1 the cycle after the commit, dbg_data=stored word.
- FIFO fill and overflow: dbg_ready=0, commit pushes 1,2,3,4,5 -> status read = 3'b010 (full) after 4 pushes, 3'b110 (overflow, full) after the 5th; drain yields 1,2,3,4, then dbg_valid=0.
- Simultaneous push and pop at full: count stays 4; order preserved; overflow stays 0.
- Commit gating: wren held 4 cycles at 0xF00 with one proc_step pulse -> exactly one FIFO entry.
- Counter: read 0xF02 on two accesses N cycles apart -> difference N; write 0xF03 -> next read equals cycles since the clear; reset mid-run -> counter 0, dbg_valid 0, q_dmem 0.

Source files
------------

// File: rtl/dmem_mmio_bridge_if.sv
// Processor data port, dmem port and debug drain port seen by dmem_mmio_bridge.
// slave is the bridge's view; master is the surrounding processor/dmem/consumer.
interface dmem_mmio_bridge_if;
  logic        proc_step;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [11:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic        dbg_valid;
  logic [31:0] dbg_data;
  logic        dbg_ready;

  modport slave (
    input  proc_step, address_dmem, data, wren, mem_q, dbg_ready,
    output q_dmem, mem_address, mem_data, mem_wren, dbg_valid, dbg_data
  );

  modport master (
    output proc_step, address_dmem, data, wren, mem_q, dbg_ready,
    input  q_dmem, mem_address, mem_data, mem_wren, dbg_valid, dbg_data
  );
endinterface

// File: rtl/dmem_mmio_bridge.sv
// Splits processor data accesses between dmem and an MMIO page holding a debug
// FIFO, its status register and a free-running cycle counter.
module dmem_mmio_bridge #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [11:0] MMIO_BASE  = 12'hF00
) (
  input  logic              clock,
  input  logic              reset,
  dmem_mmio_bridge_if.slave bus
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic          is_mem;
  logic [11:0]   offset;
  logic          commit, push_req, stat_wr, clr_req, push, pop;
  logic          empty, full;
  logic [31:0]   mmio_val;

  logic [31:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          sel_mem_q;
  logic [31:0]   mmio_rd_q;

  assign is_mem = bus.address_dmem < MMIO_BASE;
  assign offset = bus.address_dmem - MMIO_BASE;

  assign bus.mem_address = bus.address_dmem;
  assign bus.mem_data    = bus.data;
  assign bus.mem_wren    = bus.wren & is_mem;

  // proc_step marks the single cycle a store may commit, however long wren is held
  assign commit   = bus.proc_step & bus.wren & ~is_mem;
  assign push_req = commit & (offset == 12'd0);
  assign stat_wr  = commit & (offset == 12'd1);
  assign clr_req  = commit & (offset == 12'd3);

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign pop   = ~empty & bus.dbg_ready;
  assign push  = push_req & (~full | pop);

  assign bus.dbg_valid = ~empty;
  assign bus.dbg_data  = fifo_mem_q[rd_ptr_q];
  assign bus.q_dmem    = sel_mem_q ? bus.mem_q : mmio_rd_q;

  always_comb begin
    mmio_val = '0;
    case (offset)
      12'd1:   mmio_val = {29'b0, ovf_q, full, empty};
      12'd2:   mmio_val = cycle_q;
      default: mmio_val = '0;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    cycle_d  = clr_req ? '0 : cycle_q + 32'd1;
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    if (push_req && !push) ovf_d = 1'b1;
    else if (stat_wr)      ovf_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      cycle_q   <= '0;
      sel_mem_q <= 1'b0;
      mmio_rd_q <= '0;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      ovf_q     <= ovf_d;
      cycle_q   <= cycle_d;
      sel_mem_q <= is_mem;
      mmio_rd_q <= mmio_val;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) fifo_mem_q[wr_ptr_q] <= bus.data;
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge: vector table for single-access behaviour,
// hand-written sequences for FIFO fill/drain, commit gating, counter and reset.
module tb_dmem_mmio_bridge;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  dmem_mmio_bridge_if bus ();

  dmem_mmio_bridge #(.FIFO_DEPTH(4), .MMIO_BASE(12'hF00)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // dmem model: synchronous RAM, read-before-write, one cycle latency
  logic [31:0] ram [4096];
  always @(posedge clock) begin
    bus.mem_q <= ram[bus.mem_address];
    if (bus.mem_wren) ram[bus.mem_address] <= bus.mem_data;
  end

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic        step;
    logic        rdy;
    logic        exp_mwren;
    logic        chk_q;
    logic [31:0] exp_q;
    logic        exp_valid;
    logic        chk_dat;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic we,
                       input logic st, input logic rdy);
    bus.address_dmem = a;
    bus.data         = d;
    bus.wren         = we;
    bus.proc_step    = st;
    bus.dbg_ready    = rdy;
  endtask

  task automatic tick(input logic [11:0] a, input logic [31:0] d, input logic we,
                      input logic st, input logic rdy);
    drive(a, d, we, st, rdy);
    @(posedge clock);
    #1;
  endtask

  logic [31:0] c1, c2;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    drive(12'h000, '0, 1'b0, 1'b0, 1'b0);

    //            addr     wdata         we    st    rdy   mwren chkq  exp_q          valid chkd  exp_dat
    vecs[0]  = '{12'hF01, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 1'b0, 32'h0};
    vecs[1]  = '{12'h010, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[2]  = '{12'h010, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{12'hF00, 32'h11,       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 32'h11};
    vecs[4]  = '{12'hF01, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 32'h11};
    vecs[5]  = '{12'hF00, 32'h22,       1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 32'h11};
    vecs[6]  = '{12'hF04, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[7]  = '{12'hF01, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 1'b0, 32'h0};
    vecs[8]  = '{12'hF04, 32'h99,       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[9]  = '{12'hF01, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 1'b0, 32'h0};
    vecs[10] = '{12'hEFF, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[11] = '{12'hEFF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{12'hFFF, 32'h5,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};

    repeat (2) @(posedge clock);
    #1;
    check("reset q_dmem", bus.q_dmem, 32'h0);
    check("reset dbg_valid", {31'b0, bus.dbg_valid}, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].wren, vecs[i].step, vecs[i].rdy);
      #1;
      check($sformatf("v%0d mem_wren", i), {31'b0, bus.mem_wren}, {31'b0, vecs[i].exp_mwren});
      check($sformatf("v%0d mem_address", i), {20'b0, bus.mem_address}, {20'b0, vecs[i].addr});
      @(posedge clock);
      #1;
      if (vecs[i].chk_q) check($sformatf("v%0d q_dmem", i), bus.q_dmem, vecs[i].exp_q);
      check($sformatf("v%0d dbg_valid", i), {31'b0, bus.dbg_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].chk_dat) check($sformatf("v%0d dbg_data", i), bus.dbg_data, vecs[i].exp_dat);
    end

    // FIFO fill, overflow, drain
    for (int k = 1; k <= 4; k++) tick(12'hF00, 32'(k), 1'b1, 1'b1, 1'b0);
    tick(12'hF01, '0, 1'b0, 1'b0, 1'b0);
    check("status full", bus.q_dmem, 32'h2);
    tick(12'hF00, 32'd5, 1'b1, 1'b1, 1'b0);
    tick(12'hF01, '0, 1'b0, 1'b0, 1'b0);
    check("status ovf+full", bus.q_dmem, 32'h6);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain%0d valid", k), {31'b0, bus.dbg_valid}, 32'h1);
      check($sformatf("drain%0d data", k), bus.dbg_data, 32'(k));
      tick(12'h000, '0, 1'b0, 1'b0, 1'b1);
    end
    check("drained valid", {31'b0, bus.dbg_valid}, 32'h0);
    tick(12'hF01, '0, 1'b0, 1'b0, 1'b0);
    check("status ovf sticky", bus.q_dmem, 32'h5);
    tick(12'hF01, 32'hFFFF, 1'b1, 1'b1, 1'b0);
    tick(12'hF01, '0, 1'b0, 1'b0, 1'b0);
    check("status ovf cleared", bus.q_dmem, 32'h1);

    // simultaneous push and pop while full
    for (int k = 10; k <= 13; k++) tick(12'hF00, 32'(k), 1'b1, 1'b1, 1'b0);
    check("full head", bus.dbg_data, 32'd10);
    tick(12'hF00, 32'd14, 1'b1, 1'b1, 1'b1);
    check("pushpop head", bus.dbg_data, 32'd11);
    tick(12'hF01, '0, 1'b0, 1'b0, 1'b0);
    check("pushpop status", bus.q_dmem, 32'h2);
    for (int k = 11; k <= 14; k++) begin
      check($sformatf("pp drain%0d", k), bus.dbg_data, 32'(k));
      tick(12'h000, '0, 1'b0, 1'b0, 1'b1);
    end
    check("pp drained valid", {31'b0, bus.dbg_valid}, 32'h0);

    // wren held four cycles, one proc_step
    tick(12'hF00, 32'hA5A5, 1'b1, 1'b0, 1'b0);
    tick(12'hF00, 32'hA5A5, 1'b1, 1'b1, 1'b0);
    tick(12'hF00, 32'hA5A5, 1'b1, 1'b0, 1'b0);
    tick(12'hF00, 32'hA5A5, 1'b1, 1'b0, 1'b0);
    check("gate data", bus.dbg_data, 32'hA5A5);
    tick(12'h000, '0, 1'b0, 1'b0, 1'b1);
    check("gate single entry", {31'b0, bus.dbg_valid}, 32'h0);

    // cycle counter: 8 edges between two reads, then clear
    tick(12'hF02, '0, 1'b0, 1'b0, 1'b0);
    c1 = bus.q_dmem;
    repeat (7) tick(12'h000, '0, 1'b0, 1'b0, 1'b0);
    tick(12'hF02, '0, 1'b0, 1'b0, 1'b0);
    c2 = bus.q_dmem;
    check("counter delta", c2 - c1, 32'd8);
    tick(12'hF03, 32'h1234, 1'b1, 1'b1, 1'b0);
    repeat (3) tick(12'h000, '0, 1'b0, 1'b0, 1'b0);
    tick(12'hF02, '0, 1'b0, 1'b0, 1'b0);
    check("counter after clear", bus.q_dmem, 32'd3);

    // reset mid-run, with a competing push commit
    tick(12'hF00, 32'h77, 1'b1, 1'b1, 1'b0);
    check("pre-reset valid", {31'b0, bus.dbg_valid}, 32'h1);
    reset = 1'b1;
    tick(12'hF00, 32'h88, 1'b1, 1'b1, 1'b0);
    check("mid reset valid", {31'b0, bus.dbg_valid}, 32'h0);
    check("mid reset q_dmem", bus.q_dmem, 32'h0);
    reset = 1'b0;
    tick(12'hF02, '0, 1'b0, 1'b0, 1'b0);
    check("counter after reset", bus.q_dmem, 32'h0);
    tick(12'hF01, '0, 1'b0, 1'b0, 1'b0);
    check("status after reset", bus.q_dmem, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
